// File: rtl/tt_uart_pkg.sv
// Shared definitions for the tile's UART link; the receive side imports this too.
package tt_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tt_sync_fifo.sv
// Small synchronous FIFO with fall-through head; a push and a pop may share one edge.
module tt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tt_uart_tx.sv
// UART transmitter: valid/ready byte port into a FIFO, serialised 8N1 (optional even parity) on tx.
// Handshake: a byte is taken on any rising edge where in_valid && in_ready; the source holds in_valid and in_data until then.
module tt_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output tx_state_t                     state
);

    localparam int             CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state_n;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    bit_idx;
    logic [2:0]    idx_n;
    logic [7:0]    shreg;
    logic [7:0]    shreg_n;
    logic          tx_n;
    logic          busy_n;
    logic          bit_done;
    logic          pop;
    logic          push;
    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic          fifo_empty;

    // in_ready is !full, i.e. fifo_count < FIFO_DEPTH.
    assign in_ready = ~fifo_full;
    assign push     = in_valid && in_ready;
    assign bit_done = (baud_cnt == '0);

    tt_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_n = state;
        cnt_n   = bit_done ? CNT_MAX : baud_cnt - 1'b1;
        idx_n   = bit_idx;
        shreg_n = shreg;
        tx_n    = tx;
        busy_n  = busy;
        pop     = 1'b0;

        case (state)
            IDLE: begin
                tx_n  = IDLE_LEVEL;
                cnt_n = CNT_MAX;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_data;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (bit_done) begin
                    tx_n    = shreg[0];
                    idx_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            tx_n    = ^shreg;
                            state_n = PARITY;
                        end else begin
                            tx_n    = STOP_LEVEL;
                            state_n = STOP;
                        end
                    end else begin
                        idx_n = bit_idx + 3'd1;
                        tx_n  = shreg[idx_n];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    tx_n    = STOP_LEVEL;
                    state_n = STOP;
                end
            end
            STOP: begin
                // A queued byte starts its START bit straight from here, no idle gap.
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_n = fifo_data;
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        tx_n    = IDLE_LEVEL;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                tx_n    = IDLE_LEVEL;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= CNT_MAX;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= IDLE_LEVEL;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= cnt_n;
            bit_idx  <= idx_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            busy     <= busy_n;
        end
    end

endmodule
